// File: rtl/irq_ctrl.sv
// irq_ctrl: single-level interrupt controller with a small CPU register window.
// Each source passes a two-flop synchronizer and a rising-edge detector that sets
// a pending bit. The lowest-indexed enabled pending source is taken on intack.
// Nesting is not supported. rti returns the controller to IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stb, we, addr       IO select, write strobe, word select (0 pending, 1 ctrl/status)
//   data_in, data_out   CPU write data / read data (0 when stb=0)
//   ack                 transfer acknowledge (= stb, zero wait)
//   irq_in              raw interrupt sources, asynchronous to clk
//   intack, rti         CPU interrupt acknowledge / return-from-interrupt pulses
//   irq                 interrupt request to the CPU (combinational)
//
// Build option: define IRQ_CTRL_LEVEL_EN to add a per-source level-mode mask at
// addr 1 bits [31:24]. Without it, every source is edge-mode and those bits read 0.
module irq_ctrl #(
    parameter int unsigned num_src = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stb,
    input  logic               we,
    input  logic               addr,
    input  logic [31:0]        data_in,
    output logic [31:0]        data_out,
    output logic               ack,
    input  logic [num_src-1:0] irq_in,
    input  logic               intack,
    input  logic               rti,
    output logic               irq
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FIELD_W = 8;
    localparam int unsigned ACT_W   = 3;
    localparam int unsigned SET_W   = 2;

    typedef enum logic {IDLE, SERVICE} state_e;

    state_e               state_q, state_d;
    logic [num_src-1:0]   sync1_q, sync2_q, prev_q, edge_q;
    logic [num_src-1:0]   pending_q, pending_d;
    logic [num_src-1:0]   enable_q, enable_d;
    logic [ACT_W-1:0]     active_q, active_d;
    logic [SET_W-1:0]     settle_q;
    logic [num_src-1:0]   req_c, grant_c, clr_c, rise_c;
    logic [ACT_W-1:0]     lowest_c;
    logic                 wr_pend_c, wr_ctrl_c, unused_c;

    assign wr_pend_c = stb && we && !addr;
    assign wr_ctrl_c = stb && we && addr;
    assign unused_c  = ^data_in;

`ifdef IRQ_CTRL_LEVEL_EN
    logic [num_src-1:0] level_q, level_d;

    // Level-mode mask register
    always_comb begin
        level_d = level_q;
        if (wr_ctrl_c) level_d = data_in[24 +: num_src];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) level_q <= '0;
        else        level_q <= level_d;
    end
`else
    logic [num_src-1:0] level_q;
    assign level_q = '0;
`endif

    // Edges are suppressed until the synchronizer has refilled after reset, so a
    // source held high through reset does not look like a fresh rising edge.
    assign rise_c = sync2_q & ~prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            settle_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= (settle_q == SET_W'(3)) ? rise_c : '0;
            if (settle_q != SET_W'(3)) settle_q <= settle_q + SET_W'(1);
        end
    end

    // Lowest-indexed enabled pending source: number and one-hot grant
    assign req_c = pending_q & enable_q;

    always_comb begin
        lowest_c = '0;
        grant_c  = '0;
        for (int i = int'(num_src) - 1; i >= 0; i--) begin
            if (req_c[i]) begin
                lowest_c   = ACT_W'(i);
                grant_c    = '0;
                grant_c[i] = 1'b1;
            end
        end
    end

    // Next state, active latch, enable and pending update (new edges beat clears)
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        enable_d = enable_q;
        clr_c    = '0;
        case (state_q)
            IDLE: begin
                if (intack && (|req_c)) begin
                    state_d  = SERVICE;
                    active_d = lowest_c;
                    clr_c    = grant_c;
                end
            end
            SERVICE: begin
                if (rti) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (wr_pend_c) clr_c = clr_c | data_in[num_src-1:0];
        if (wr_ctrl_c) enable_d = data_in[num_src-1:0];
        pending_d = (pending_q & ~clr_c) | edge_q | (level_q & sync2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            active_q  <= '0;
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
        end
    end

    assign irq = (|req_c) && (state_q == IDLE);
    assign ack = stb;

    // Read multiplexer
    always_comb begin
        data_out = '0;
        if (stb) begin
            if (!addr) begin
                data_out = DATA_W'(pending_q);
            end else begin
                data_out[7:0]   = FIELD_W'(enable_q);
                data_out[10:8]  = active_q;
                data_out[11]    = (state_q == SERVICE);
                data_out[23:16] = FIELD_W'(sync2_q);
                data_out[31:24] = FIELD_W'(level_q);
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (num_src = 8).
module tb_irq_ctrl;

    localparam int unsigned NS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic          addr = 1'b0;
    logic [31:0]   data_in = '0;
    logic [31:0]   data_out;
    logic          ack;
    logic [NS-1:0] irq_in = '0;
    logic          intack = 1'b0;
    logic          rti = 1'b0;
    logic          irq;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   rv;

    always #10 clk = ~clk;

    irq_ctrl #(.num_src(NS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stb      (stb),
        .we       (we),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ack      (ack),
        .irq_in   (irq_in),
        .intack   (intack),
        .rti      (rti),
        .irq      (irq)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic a, output logic [31:0] v);
        stb  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        v    = data_out;
        stb  = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        stb     = 1'b1;
        we      = 1'b1;
        addr    = a;
        data_in = d;
        tick;
        stb     = 1'b0;
        we      = 1'b0;
        data_in = '0;
    endtask

    task automatic pulse_src(input logic [NS-1:0] m);
        irq_in = m;
        tick;
        irq_in = '0;
        tick;
        tick;
        tick;
    endtask

    task automatic pulse_intack;
        intack = 1'b1;
        tick;
        intack = 1'b0;
    endtask

    task automatic pulse_rti;
        rti = 1'b1;
        tick;
        rti = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_pending: got %h exp 00000000", rv); end
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h exp 00000000", rv); end
        stb = 1'b1;
        #1;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL ack_hi: got %b exp 1", ack); end
        stb = 1'b0;
        #1;
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_lo: got %b exp 0", ack); end
        tick;
        tick;
        rst_n = 1'b1;
        repeat (5) tick;
    endtask

    task automatic test_edge_latency;
        wr(1'b1, 32'h0000_0001);
        irq_in = 8'h01;
        tick;
        irq_in = '0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lat_n0: got %b exp 0", irq); end
        tick;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lat_n1: got %b exp 0", irq); end
        tick;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lat_n2: got %b exp 0", irq); end
        tick;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lat_n3: got %b exp 1", irq); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h01) begin errors++; $display("FAIL lat_pending: got %h exp 00000001", rv); end
        #1;
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL stb0_zero: got %h exp 00000000", data_out); end
        wr(1'b0, 32'h0000_0001);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b exp 0", irq); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL w1c_pending: got %h exp 00000000", rv); end
    endtask

    task automatic test_priority;
        wr(1'b1, 32'h0000_00FF);
        pulse_src(8'h14);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h14) begin errors++; $display("FAIL pri_pending: got %h exp 00000014", rv); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pri_irq: got %b exp 1", irq); end
        pulse_intack;
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_0AFF) begin errors++; $display("FAIL pri_ack1_ctrl: got %h exp 00000AFF", rv); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h10) begin errors++; $display("FAIL pri_ack1_pending: got %h exp 00000010", rv); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pri_svc_irq: got %b exp 0", irq); end
        pulse_rti;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pri_rti_irq: got %b exp 1", irq); end
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_02FF) begin errors++; $display("FAIL pri_rti_ctrl: got %h exp 000002FF", rv); end
        pulse_intack;
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_0CFF) begin errors++; $display("FAIL pri_ack2_ctrl: got %h exp 00000CFF", rv); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL pri_ack2_pending: got %h exp 00000000", rv); end
        pulse_rti;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pri_end_irq: got %b exp 0", irq); end
    endtask

    task automatic test_ignored_intack;
        pulse_intack;
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_04FF) begin errors++; $display("FAIL ign_ctrl: got %h exp 000004FF", rv); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ign_irq: got %b exp 0", irq); end
    endtask

    task automatic test_conflict;
        pulse_src(8'h03);
        pulse_intack;
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_08FF) begin errors++; $display("FAIL cf_svc_ctrl: got %h exp 000008FF", rv); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h02) begin errors++; $display("FAIL cf_svc_pending: got %h exp 00000002", rv); end
        pulse_intack;
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_08FF) begin errors++; $display("FAIL cf_nest_ctrl: got %h exp 000008FF", rv); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h02) begin errors++; $display("FAIL cf_nest_pending: got %h exp 00000002", rv); end
        intack = 1'b1;
        rti    = 1'b1;
        tick;
        intack = 1'b0;
        rti    = 1'b0;
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0000_00FF) begin errors++; $display("FAIL cf_both_ctrl: got %h exp 000000FF", rv); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h02) begin errors++; $display("FAIL cf_both_pending: got %h exp 00000002", rv); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL cf_both_irq: got %b exp 1", irq); end
        wr(1'b0, 32'h0000_0002);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL cf_clear: got %h exp 00000000", rv); end
    endtask

    task automatic test_clear_race;
        pulse_src(8'h08);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h08) begin errors++; $display("FAIL race_pre: got %h exp 00000008", rv); end
        irq_in = 8'h08;
        tick;
        irq_in = '0;
        tick;
        tick;
        wr(1'b0, 32'h0000_0008);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h08) begin errors++; $display("FAIL race_edge_wins: got %h exp 00000008", rv); end
        wr(1'b1, 32'h0000_0000);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL dis_irq: got %b exp 0", irq); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h08) begin errors++; $display("FAIL dis_pending: got %h exp 00000008", rv); end
        wr(1'b1, 32'h0000_00FF);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL reen_irq: got %b exp 1", irq); end
        wr(1'b0, 32'h0000_0008);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL race_clear: got %h exp 00000000", rv); end
    endtask

    task automatic test_reset_mid_service;
        pulse_src(8'h01);
        pulse_intack;
        irq_in = 8'h80;
        repeat (4) tick;
        rd(1'b0, rv);
        checks++; if (rv !== 32'h80) begin errors++; $display("FAIL rms_pending: got %h exp 00000080", rv); end
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0080_08FF) begin errors++; $display("FAIL rms_ctrl: got %h exp 008008FF", rv); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rms_async_irq: got %b exp 0", irq); end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rms_async_pending: got %h exp 00000000", rv); end
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rms_async_ctrl: got %h exp 00000000", rv); end
        tick;
        tick;
        rst_n = 1'b1;
        wr(1'b1, 32'h0000_0080);
        for (int k = 0; k < 10; k++) begin
            tick;
            checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rms_post_irq cycle %0d: got %b exp 0", k, irq); end
        end
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL rms_post_pending: got %h exp 00000000", rv); end
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0080_0080) begin errors++; $display("FAIL rms_post_ctrl: got %h exp 00800080", rv); end
        irq_in = '0;
        repeat (3) tick;
    endtask

    task automatic test_upper_bits;
        logic [31:0] exp;
`ifdef IRQ_CTRL_LEVEL_EN
        exp = 32'hFF00_00FF;
`else
        exp = 32'h0000_00FF;
`endif
        wr(1'b1, 32'hFFFF_FFFF);
        rd(1'b1, rv);
        checks++; if (rv !== exp) begin errors++; $display("FAIL upper_ctrl: got %h exp %h", rv, exp); end
        wr(1'b1, 32'h0000_0000);
        rd(1'b1, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL upper_cleared: got %h exp 00000000", rv); end
    endtask

`ifdef IRQ_CTRL_LEVEL_EN
    task automatic test_level;
        wr(1'b1, 32'h0200_0002);
        irq_in = 8'h02;
        repeat (4) tick;
        rd(1'b0, rv);
        checks++; if (rv !== 32'h02) begin errors++; $display("FAIL lvl_set: got %h exp 00000002", rv); end
        wr(1'b0, 32'h0000_0002);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h02) begin errors++; $display("FAIL lvl_hold: got %h exp 00000002", rv); end
        irq_in = '0;
        repeat (3) tick;
        wr(1'b0, 32'h0000_0002);
        rd(1'b0, rv);
        checks++; if (rv !== 32'h0) begin errors++; $display("FAIL lvl_clear: got %h exp 00000000", rv); end
        wr(1'b1, 32'h0000_0000);
    endtask
`endif

    initial begin
        test_reset;
        test_edge_latency;
        test_priority;
        test_ignored_intack;
        test_conflict;
        test_clear_race;
        test_reset_mid_service;
        test_upper_bits;
`ifdef IRQ_CTRL_LEVEL_EN
        test_level;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
